// File: rtl/data_memory_lat_if.sv
// Request/response bundle between a requester and data_memory_lat.
// Optional: MEM_RANGE_CHECK_EN adds err_o (out-of-range request flag).
//
// Handshake: the requester raises enable_i with addr_i/data_i/write_i valid;
// the memory samples them on the first edge it is idle (busy_o low) and then
// ignores the request lines until it answers with a one-cycle ack_o pulse.
// The requester must drop enable_i on seeing ack_o, otherwise a still-high
// enable_i in that cycle starts a new request.
interface data_memory_lat_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [LINE_WIDTH-1:0] data_i;
    logic                  enable_i;
    logic                  write_i;
    logic                  ack_o;
    logic [LINE_WIDTH-1:0] data_o;
    logic                  busy_o;
    logic [1:0]            state_dbg;
`ifdef MEM_RANGE_CHECK_EN
    logic                  err_o;

    modport master (
        output addr_i, data_i, enable_i, write_i,
        input  ack_o, data_o, busy_o, state_dbg, err_o
    );
    modport slave (
        input  addr_i, data_i, enable_i, write_i,
        output ack_o, data_o, busy_o, state_dbg, err_o
    );
`else
    modport master (
        output addr_i, data_i, enable_i, write_i,
        input  ack_o, data_o, busy_o, state_dbg
    );
    modport slave (
        input  addr_i, data_i, enable_i, write_i,
        output ack_o, data_o, busy_o, state_dbg
    );
`endif
endinterface

// File: rtl/data_memory_lat.sv
// Line-granular backing memory with configurable access latency.
// One request in flight; ack_o pulses LATENCY cycles after acceptance.
// Optional: MEM_RANGE_CHECK_EN flags requests whose address has nonzero
// bits above the line index (write suppressed, read returns zero, err_o).
module data_memory_lat #(
    parameter int LINE_WIDTH = 256,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int LATENCY    = 10
) (
    input logic            clk_i,
    input logic            rst_i,
    data_memory_lat_if.slave bus
);
    localparam int OFF = $clog2(LINE_WIDTH / 8);
    localparam int IDX = $clog2(DEPTH);
    localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                state;
    logic [CW-1:0]         counter;
    logic [IDX-1:0]        req_idx;
    logic [LINE_WIDTH-1:0] req_data;
    logic                  req_write;
    logic                  ack_q;
    logic                  busy_q;
    logic [LINE_WIDTH-1:0] data_q;

    logic [LINE_WIDTH-1:0] memory [0:DEPTH-1];

    logic [IDX-1:0]        addr_idx;
    logic                  unused_addr;

    assign addr_idx = bus.addr_i[OFF+IDX-1:OFF];

`ifdef MEM_RANGE_CHECK_EN
    logic addr_oor;
    logic req_oor;
    logic err_q;

    assign addr_oor    = |bus.addr_i[ADDR_WIDTH-1:OFF+IDX];
    assign unused_addr = ^bus.addr_i[OFF-1:0];
    assign bus.err_o   = err_q;
`else
    // Upper bits are dropped, so addresses alias modulo DEPTH.
    assign unused_addr = ^{bus.addr_i[ADDR_WIDTH-1:OFF+IDX], bus.addr_i[OFF-1:0]};
`endif

    assign bus.ack_o     = ack_q;
    assign bus.busy_o    = busy_q;
    assign bus.data_o    = data_q;
    assign bus.state_dbg = state;

    // Request FSM: accept in IDLE, count down in WAIT, perform the access on
    // the edge that leaves ACK (counter has reached 0) and raise ack_o there.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            counter   <= '0;
            req_idx   <= '0;
            req_data  <= '0;
            req_write <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
`ifdef MEM_RANGE_CHECK_EN
            req_oor   <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    ack_q <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
                    err_q <= 1'b0;
`endif
                    if (bus.enable_i) begin
                        req_idx   <= addr_idx;
                        req_data  <= bus.data_i;
                        req_write <= bus.write_i;
`ifdef MEM_RANGE_CHECK_EN
                        req_oor   <= addr_oor;
`endif
                        counter   <= CNT_LOAD;
                        busy_q    <= 1'b1;
                        // With a single-cycle latency there is nothing to wait for.
                        state     <= (LATENCY == 1) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
`ifdef MEM_RANGE_CHECK_EN
                    if (req_write) begin
                        if (!req_oor) begin
                            memory[req_idx] <= req_data;
                        end
                    end else begin
                        data_q <= req_oor ? '0 : memory[req_idx];
                    end
                    err_q <= req_oor;
`else
                    if (req_write) begin
                        memory[req_idx] <= req_data;
                    end else begin
                        data_q <= memory[req_idx];
                    end
`endif
                    ack_q  <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_lat.sv
// Directed bench for data_memory_lat: a LATENCY=10 default instance and a
// small LATENCY=1 instance driven back-to-back.
// Optional: MEM_RANGE_CHECK_EN switches the out-of-range expectations.
module tb_data_memory_lat;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_memory_lat_if #(.LINE_WIDTH(256), .ADDR_WIDTH(32)) bus0 ();
    data_memory_lat_if #(.LINE_WIDTH(32),  .ADDR_WIDTH(16)) bus1 ();

    data_memory_lat #(
        .LINE_WIDTH(256), .DEPTH(512), .ADDR_WIDTH(32), .LATENCY(10)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus0.slave)
    );

    data_memory_lat #(
        .LINE_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(16), .LATENCY(1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1.slave)
    );

    localparam logic [255:0] P1 = {128'h8888_8888_8888_8888_8888_8888_8888_8888, 128'h0};
    localparam logic [255:0] A5 = {32{8'hA5}};
    localparam logic [255:0] QV = {2{128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210}};
    localparam logic [255:0] Z0 = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] Z1 = {8{32'h5555_AAAA}};

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One request on the LATENCY=10 instance. Accepted at edge T; enable is
    // dropped and addr_i changed to late_addr in the first cycle after T.
    // Observation index j is the cycle following edge T+j.
    task automatic req0(input logic [31:0] addr, input logic [255:0] data, input logic wr,
                        input logic [31:0] late_addr, input int probe_idx,
                        output int ack_at, output int n_ack, output int n_busy,
                        output logic [255:0] pre_mem, output logic [255:0] post_mem,
                        output logic [255:0] pre_do, output logic [255:0] post_do,
                        output logic err_seen);
        ack_at = -1; n_ack = 0; n_busy = 0; err_seen = 1'b0;
        pre_mem = '0; post_mem = '0; pre_do = '0; post_do = '0;
        @(negedge clk);
        bus0.addr_i   = addr;
        bus0.data_i   = data;
        bus0.write_i  = wr;
        bus0.enable_i = 1'b1;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (j == 0) begin
                bus0.enable_i = 1'b0;
                bus0.addr_i   = late_addr;
                bus0.data_i   = ~data;
                bus0.write_i  = ~wr;
            end
            if (bus0.ack_o) begin
                n_ack++;
                ack_at = j;
`ifdef MEM_RANGE_CHECK_EN
                err_seen = bus0.err_o;
`endif
            end
            if (bus0.busy_o) n_busy++;
            if (j == 9) begin
                pre_mem = dut.memory[probe_idx];
                pre_do  = bus0.data_o;
            end
            if (j == 10) begin
                post_mem = dut.memory[probe_idx];
                post_do  = bus0.data_o;
            end
        end
    endtask

    task automatic write0(input logic [31:0] addr, input logic [255:0] data);
        int a, n, b; logic [255:0] m0, m1, d0, d1; logic e;
        req0(addr, data, 1'b1, addr, 0, a, n, b, m0, m1, d0, d1, e);
    endtask

    initial begin
        int ack_at, n_ack, n_busy;
        logic [255:0] pre_mem, post_mem, pre_do, post_do;
        logic err_seen;
        logic [7:0] ack_pat, busy_pat;

        bus0.addr_i = '0; bus0.data_i = '0; bus0.enable_i = 1'b0; bus0.write_i = 1'b0;
        bus1.addr_i = '0; bus1.data_i = '0; bus1.enable_i = 1'b0; bus1.write_i = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {255'b0, bus0.ack_o}, 256'd0);
        check("rst_busy", {255'b0, bus0.busy_o}, 256'd0);
        check("rst_data", bus0.data_o, 256'd0);
        check("rst_ack1", {255'b0, bus1.ack_o}, 256'd0);
        check("rst_data1", {224'b0, bus1.data_o}, 256'd0);
        rst = 1'b0;

        // Read with default latency
        write0(32'h20, P1);
        req0(32'h20, '0, 1'b0, 32'h20, 1, ack_at, n_ack, n_busy,
             pre_mem, post_mem, pre_do, post_do, err_seen);
        check("rd_ack_cycle", 256'(ack_at), 256'd10);
        check("rd_ack_count", 256'(n_ack), 256'd1);
        check("rd_busy_cycles", 256'(n_busy), 256'd10);
        check("rd_data", bus0.data_o, P1);

        // Write then read; memory changes exactly at the ack edge
        write0(32'h400, 256'd1);
        req0(32'h400, A5, 1'b1, 32'h400, 32, ack_at, n_ack, n_busy,
             pre_mem, post_mem, pre_do, post_do, err_seen);
        check("wr_mem_before", pre_mem, 256'd1);
        check("wr_mem_after", post_mem, A5);
        check("wr_ack_cycle", 256'(ack_at), 256'd10);
        check("wr_data_o_held", post_do, P1);
        req0(32'h400, '0, 1'b0, 32'h400, 32, ack_at, n_ack, n_busy,
             pre_mem, post_mem, pre_do, post_do, err_seen);
        check("raw_data", bus0.data_o, A5);

        // Inputs changed during WAIT do not retarget the request
        write0(32'h40, Z1);
        req0(32'h20, '0, 1'b0, 32'h40, 2, ack_at, n_ack, n_busy,
             pre_mem, post_mem, pre_do, post_do, err_seen);
        check("chg_data", bus0.data_o, P1);
        check("chg_ack_count", 256'(n_ack), 256'd1);
        check("chg_mem_intact", dut.memory[2], Z1);

        // Reset in the middle of a write
        write0(32'h200, QV);
        @(negedge clk);
        bus0.addr_i = 32'h200; bus0.data_i = A5; bus0.write_i = 1'b1; bus0.enable_i = 1'b1;
        n_ack = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            bus0.enable_i = 1'b0;
            if (bus0.ack_o) n_ack++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_ack", {255'b0, bus0.ack_o}, 256'd0);
        check("rstw_busy", {255'b0, bus0.busy_o}, 256'd0);
        check("rstw_data", bus0.data_o, 256'd0);
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (bus0.ack_o) n_ack++;
        end
        check("rstw_no_ack", 256'(n_ack), 256'd0);
        check("rstw_mem", dut.memory[16], QV);

        // Address above the line index range
        write0(32'h0, Z0);
        req0(32'h4000, '0, 1'b0, 32'h4000, 0, ack_at, n_ack, n_busy,
             pre_mem, post_mem, pre_do, post_do, err_seen);
        check("oor_ack_cycle", 256'(ack_at), 256'd10);
`ifdef MEM_RANGE_CHECK_EN
        check("oor_rd_data", bus0.data_o, 256'd0);
        check("oor_rd_err", {255'b0, err_seen}, 256'd1);
        write0(32'h4000, Z1);
        check("oor_wr_mem", dut.memory[0], Z0);
        @(negedge clk);
        check("oor_err_idle", {255'b0, bus0.err_o}, 256'd0);
`else
        check("alias_rd_data", bus0.data_o, Z0);
        write0(32'h4000, Z1);
        check("alias_wr_mem", dut.memory[0], Z1);
`endif

        // LATENCY=1 with enable held: acks every 2 cycles
        @(negedge clk);
        bus1.addr_i = 16'h0; bus1.data_i = 32'h1111_1111; bus1.write_i = 1'b1; bus1.enable_i = 1'b1;
        @(negedge clk);
        bus1.enable_i = 1'b0;
        repeat (3) @(negedge clk);
        bus1.write_i = 1'b0; bus1.enable_i = 1'b1;
        ack_pat = '0; busy_pat = '0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            ack_pat[j]  = bus1.ack_o;
            busy_pat[j] = bus1.busy_o;
        end
        bus1.enable_i = 1'b0;
        check("lat1_ack_pattern", {248'b0, ack_pat}, 256'hAA);
        check("lat1_busy_pattern", {248'b0, busy_pat}, 256'h55);
        check("lat1_data", {224'b0, bus1.data_o}, 256'h1111_1111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
